// File: rtl/branch_predictor_if.sv
// Lookup and resolved-branch update bundle for branch_predictor; the _i/_o suffixes are from the predictor's side.
// The predictor uses the slave modport. The fetch/execute side uses master.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);
    logic [ADDR_W-1:0] lookup_pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_pred_taken_i;
    logic [ADDR_W-1:0] upd_pred_target_i;
    logic              upd_mispred_o;
    logic [STAT_W-1:0] branch_cnt_o;
    logic [STAT_W-1:0] mispred_cnt_o;

    modport master (
        output lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  pred_hit_o, pred_taken_o, pred_target_o, upd_mispred_o,
               branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output pred_hit_o, pred_taken_o, pred_target_o, upd_mispred_o,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating counters and branch/mispredict statistics.
// Latency: lookup and mispredict flag are combinational; table and statistics update on the next edge.
// Backpressure: none; one lookup and one resolved-branch update are accepted every cycle.
module branch_predictor #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    entry_t            tbl [DEPTH];
    logic [STAT_W-1:0] branch_cnt_q;
    logic [STAT_W-1:0] mispred_cnt_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    entry_t            lk_ent;
    logic              lk_hit;
    logic              lk_taken;

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [CNT_W-1:0]  up_cnt;
    logic [CNT_W-1:0]  up_cnt_nxt;
    logic              mispred;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^{bp.lookup_pc_i[1:0], bp.upd_pc_i[1:0]};

    // Lookup reads registered state only, so a same-cycle update to the same entry is not visible.
    assign lk_idx   = bp.lookup_pc_i[IDX_W+1:2];
    assign lk_tag   = bp.lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign lk_ent   = tbl[lk_idx];
    assign lk_hit   = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign lk_taken = lk_hit && lk_ent.cnt[CNT_W-1];

    assign bp.pred_hit_o    = lk_hit;
    assign bp.pred_taken_o  = lk_taken;
    assign bp.pred_target_o = lk_taken ? lk_ent.target : bp.lookup_pc_i + ADDR_W'(4);

    assign up_idx = bp.upd_pc_i[IDX_W+1:2];
    assign up_tag = bp.upd_pc_i[ADDR_W-1:IDX_W+2];
    assign up_hit = tbl[up_idx].valid && (tbl[up_idx].tag == up_tag);
    assign up_cnt = tbl[up_idx].cnt;

    always_comb begin
        up_cnt_nxt = up_cnt;
        if (bp.upd_taken_i) begin
            if (up_cnt != CNT_MAX) up_cnt_nxt = up_cnt + CNT_W'(1);
        end else begin
            if (up_cnt != '0) up_cnt_nxt = up_cnt - CNT_W'(1);
        end
    end

    assign mispred = bp.upd_valid_i &&
                     ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                      (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));

    assign bp.upd_mispred_o = mispred;
    assign bp.branch_cnt_o  = branch_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (bp.upd_valid_i) begin
            if (up_hit) begin
                tbl[up_idx].cnt <= up_cnt_nxt;
                if (bp.upd_taken_i) tbl[up_idx].target <= bp.upd_target_i;
            end else if (bp.upd_taken_i) begin
                // Taken miss replaces whatever occupied the slot, starting weakly taken.
                tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bp.upd_target_i, cnt: CNT_WT};
            end
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + STAT_W'(1);
            if (mispred && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
        end
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_W, default 32, PC/target width.
REQ-002 Parameter IDX_W, default 4, index width; table depth = 2**IDX_W; legal range 1..10.
REQ-003 Parameter CNT_W, default 2, saturating-counter width; legal range 1..4.
REQ-004 Parameter STAT_W, default 16, statistics-counter width.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 lookup_pc_i  input  ADDR_W  IF-stage PC to predict.
REQ-008 pred_hit_o  output  1  lookup entry valid and tag-matched.
REQ-009 pred_taken_o  output  1  predicted taken.
REQ-010 pred_target_o  output  ADDR_W  predicted next PC.
REQ-011 upd_valid_i  input  1  resolved branch present this cycle.
REQ-012 upd_pc_i  input  ADDR_W  PC of resolved branch.
REQ-013 upd_taken_i  input  1  actual outcome.
REQ-014 upd_target_i  input  ADDR_W  actual taken target.
REQ-015 upd_pred_taken_i  input  1  prediction made for that branch.
REQ-016 upd_pred_target_i  input  ADDR_W  target predicted for that branch.
REQ-017 upd_mispred_o  output  1  resolved branch was mispredicted (flush request).
REQ-018 branch_cnt_o  output  STAT_W  resolved branches counted.
REQ-019 mispred_cnt_o  output  STAT_W  mispredictions counted.

Function
REQ-020 PCs word-aligned; index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-021 Each entry: valid bit, tag, ADDR_W target, CNT_W counter; held in flops.
REQ-022 Lookup combinational from registered state, zero latency: pred_hit_o = valid & tag match.
REQ-023 pred_taken_o = pred_hit_o & counter MSB.
REQ-024 pred_target_o = stored target when pred_taken_o, else lookup_pc_i+4 (modulo 2**ADDR_W).
REQ-025 upd_mispred_o combinational = upd_valid_i & ((upd_pred_taken_i != upd_taken_i) | (upd_taken_i & upd_pred_target_i != upd_target_i)).
REQ-026 Update on rising edge with upd_valid_i=1, update hits: counter +1 if taken, -1 if not, saturating at 0 and 2**CNT_W-1; target <= upd_target_i if taken.
REQ-027 Update misses, taken: allocate/replace entry: valid=1, tag, target, counter = 2**(CNT_W-1) (weakly taken).
REQ-028 Update misses, not taken: table unchanged.
REQ-029 Same cycle, same index lookup and update: lookup reflects pre-update state; no bypass.
REQ-030 branch_cnt_o +1 per upd_valid_i cycle; mispred_cnt_o +1 per upd_mispred_o cycle; both saturate at all-ones, never wrap.
REQ-031 upd_valid_i=0: no state change.

Reset
REQ-032 rst_i=1 at rising edge: all valid=0, counters = 2**(CNT_W-1)-1 (weakly not-taken), targets/tags 0, branch_cnt_o=0, mispred_cnt_o=0.
REQ-033 rst_i dominates upd_valid_i; concurrent update discarded, statistics not incremented.
REQ-034 Outputs after reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=lookup_pc_i+4.

Verification (IDX_W=4, CNT_W=2, ADDR_W=32)
REQ-035 Reset, lookup 0x40 -> hit 0, taken 0, target 0x44, counters 0.
REQ-036 Update pc 0x40 taken target 0x100 -> next cycle lookup 0x40: hit 1, taken 1, target 0x100, counter 2.
REQ-037 Then three not-taken updates on 0x40 -> counter 1,0,0; lookup taken 0, hit 1, target 0x44; one taken update -> counter 1, still not-taken.
REQ-038 Alias: after REQ-036, taken update pc 0x80 target 0x200 (index 0, new tag) -> lookup 0x40 hit 0; lookup 0x80 hit 1, target 0x200.
REQ-039 Lookup 0x40 and taken update 0x40 same cycle, entry absent -> that cycle hit 0, target 0x44; next cycle hit 1; upd_pred_taken_i=0 -> upd_mispred_o=1, mispred_cnt_o=1.
REQ-040 STAT_W=2, five mispredicted updates -> mispred_cnt_o=3; then rst_i=1 with upd_valid_i=1 -> all counts 0, all lookups miss.
